// File: rtl/ledseq_pkg.sv
// ledseq_pkg - shared definitions for the LED sequencer.
//   state_e    : controller states (IDLE, RUN, PEND)
//   MODE_*     : pattern select codes carried on the mode input
//   PERIOD_MIN : smallest step period the divider accepts
package ledseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  localparam logic [1:0] MODE_WL  = 2'b00;  // walk-left
  localparam logic [1:0] MODE_WR  = 2'b01;  // walk-right
  localparam logic [1:0] MODE_BNC = 2'b10;  // bounce
  localparam logic [1:0] MODE_BLK = 2'b11;  // blink-all

  localparam int PERIOD_MIN = 2;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// led_seq_ctrl_if - period reload handshake.
//   period_in   : requested step period in clk cycles
//   period_load : valid; held high by the requester until period_ack
//   period_ack  : one-cycle pulse, period_in has been captured
// Handshake: the requester raises period_load with period_in stable and keeps
// both unchanged until it sees period_ack high; it then drops period_load.
// A transfer completes in the cycle period_ack is high.
// Modports: master = requester, slave = led_seq_ctrl.
interface led_seq_ctrl_if #(
  parameter int DIV_W = 32
);
  logic [DIV_W-1:0] period_in;
  logic             period_load;
  logic             period_ack;

  modport master (output period_in, output period_load, input period_ack);
  modport slave  (input period_in, input period_load, output period_ack);
endinterface

// File: rtl/led_seq_ctrl_tick_divider.sv
// tick_divider - shared step divider.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : hold the counter at 0 and suppress wrap
//   period   : active period in clk cycles (>= 2)
//   wrap     : high in the cycle the counter sits at period-1; the counter
//              returns to 0 on the following edge
module tick_divider #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] period,
  output logic             wrap
);

  logic [DIV_W-1:0] count_q, count_d;

  // >= rather than == so a count left above a shortened period still wraps.
  assign wrap = ~clear & (count_q >= (period - 1'b1));

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || wrap) count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl - LED bank sequencer driven from one programmable divider.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : pulse, begin sequencing (accepted in IDLE only)
//   stop       : pulse, halt and blank LEDs (wins over start)
//   mode       : pattern, sampled on accepted start (see ledseq_pkg)
//   prd        : period reload handshake (led_seq_ctrl_if.slave)
//   led        : LED drive, active-high
//   step_tick  : pulse in the cycle a new led value first shows
//   busy       : high in RUN and PEND
//   state_dbg  : current controller state
// Build option: define LEDSEQ_BOUNCE_EN to enable the bounce pattern; without
// it mode 10 runs walk-left and the direction flop is not built.
module led_seq_ctrl
  import ledseq_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PRESCALE = 20000000,
  parameter int DIV_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  led_seq_ctrl_if.slave       prd,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_tick,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_PEND = ST_PEND;

  logic [1:0]          state_q, state_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [1:0]          mode_q, mode_d;
  logic [DIV_W-1:0]    period_q, period_d;
  logic                ack_q, ack_d;
  logic                tick_q, tick_d;

  logic                div_clear, wrap;
  logic                start_go, load_req;
  logic [DIV_W-1:0]    period_clamped;
  logic [NUM_LEDS-1:0] one_lsb, one_msb;
  logic [NUM_LEDS-1:0] init_led, step_led;

  assign one_lsb = NUM_LEDS'(1);
  assign one_msb = one_lsb << (NUM_LEDS - 1);

  assign start_go = start & ~stop & (state_q == S_IDLE);
  // ack_q masks the request in the cycle it is acknowledged, because the
  // requester only drops period_load after it has seen the ack.
  assign load_req = prd.period_load & ~ack_q;
  assign period_clamped = (prd.period_in < DIV_W'(PERIOD_MIN)) ?
                          DIV_W'(PERIOD_MIN) : prd.period_in;
  // Clearing on stop keeps a coincident wrap from producing a step.
  assign div_clear = (state_q == S_IDLE) | stop;

  tick_divider #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .rst    (rst),
    .clear  (div_clear),
    .period (period_q),
    .wrap   (wrap)
  );

  always_comb begin
    init_led = one_lsb;
    case (mode)
      MODE_WR:  init_led = one_msb;
      MODE_BLK: init_led = '1;
      default:  init_led = one_lsb;
    endcase
  end

`ifdef LEDSEQ_BOUNCE_EN
  logic dir_q, dir_d, step_dir;  // 1 = moving toward MSB
`endif

  always_comb begin
    step_led = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
`ifdef LEDSEQ_BOUNCE_EN
    step_dir = dir_q;
`endif
    case (mode_q)
      MODE_WR:  step_led = {led_q[0], led_q[NUM_LEDS-1:1]};
      MODE_BLK: step_led = ~led_q;
`ifdef LEDSEQ_BOUNCE_EN
      // Turn around at either end without repeating the end position.
      MODE_BNC: begin
        if (dir_q) begin
          if (led_q[NUM_LEDS-1]) begin
            step_led = led_q >> 1;
            step_dir = 1'b0;
          end else begin
            step_led = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            step_led = led_q << 1;
            step_dir = 1'b1;
          end else begin
            step_led = led_q >> 1;
          end
        end
      end
`endif
      default: step_led = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    mode_d   = mode_q;
    period_d = period_q;
    ack_d    = 1'b0;
    tick_d   = 1'b0;
`ifdef LEDSEQ_BOUNCE_EN
    dir_d    = dir_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d = S_RUN;
          mode_d  = mode;
          led_d   = init_led;
`ifdef LEDSEQ_BOUNCE_EN
          dir_d   = 1'b1;
`endif
        end else if (load_req) begin
          period_d = period_clamped;
          ack_d    = 1'b1;
        end
      end
      S_RUN, S_PEND: begin
        if (stop) begin
          state_d = S_IDLE;
          led_d   = '0;
        end else begin
          if (wrap) begin
            led_d  = step_led;
            tick_d = 1'b1;
`ifdef LEDSEQ_BOUNCE_EN
            dir_d  = step_dir;
`endif
            // The reload takes effect at the wrap that ends the old interval.
            if (state_q == S_PEND) begin
              period_d = period_clamped;
              ack_d    = 1'b1;
              state_d  = S_RUN;
            end
          end
          if (state_q == S_RUN && load_req) state_d = S_PEND;
        end
      end
      default: begin
        state_d = S_IDLE;
        led_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      led_q    <= '0;
      mode_q   <= MODE_WL;
      period_q <= DIV_W'(PRESCALE);
      ack_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      ack_q    <= ack_d;
      tick_q   <= tick_d;
    end
  end

`ifdef LEDSEQ_BOUNCE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir_q <= 1'b1;
    else     dir_q <= dir_d;
  end
`endif

  assign led            = led_q;
  assign step_tick      = tick_q;
  assign busy           = (state_q != S_IDLE);
  assign state_dbg      = state_q;
  assign prd.period_ack = ack_q;

endmodule
